// File: rtl/arm_ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks the register list in ascending order,
// issuing one word transfer per register, then optional base writeback and a done pulse.
module arm_ldm_stm_seq #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] rn_val_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [3:0]        rf_addr_o,
  input  logic [31:0]       rf_rdata_i,
  output logic              rf_we_o,
  output logic [31:0]       rf_wdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i
);

  typedef enum logic [2:0] {IDLE, CALC, XFER, WB, DONE} state_e;

  state_e            state_q, state_d;
  logic              p_q, p_d, u_q, u_d, w_q, w_d, l_q, l_d;
  logic [3:0]        rn_q, rn_d;
  logic [15:0]       list_q, list_d, remain_q, remain_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d, newbase_q, newbase_d;

  logic [4:0]        count;
  logic [ADDR_W-1:0] span, start_addr;
  logic [3:0]        cur_reg;
  logic [15:0]       remain_next;

  // The S bit and condition/opcode bits play no part in sequencing.
  logic unused_inst;
  assign unused_inst = ^{inst_i[31:25], inst_i[22]};

  always_comb begin
    count = '0;
    for (int i = 0; i < 16; i++) count = count + 5'(list_q[i]);
    span = ADDR_W'(count) << 2;
    cur_reg = '0;
    for (int i = 15; i >= 0; i--) begin
      if (remain_q[i]) cur_reg = 4'(i);
    end
    remain_next = remain_q & ~(16'h0001 << cur_reg);
    case ({p_q, u_q})
      2'b01:   start_addr = base_q;
      2'b11:   start_addr = base_q + ADDR_W'(4);
      2'b00:   start_addr = base_q - span + ADDR_W'(4);
      default: start_addr = base_q - span;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      p_q       <= 1'b0;
      u_q       <= 1'b0;
      w_q       <= 1'b0;
      l_q       <= 1'b0;
      rn_q      <= '0;
      list_q    <= '0;
      remain_q  <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      newbase_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      u_q       <= u_d;
      w_q       <= w_d;
      l_q       <= l_d;
      rn_q      <= rn_d;
      list_q    <= list_d;
      remain_q  <= remain_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      newbase_q <= newbase_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    u_d         = u_q;
    w_d         = w_q;
    l_d         = l_q;
    rn_d        = rn_q;
    list_d      = list_q;
    remain_d    = remain_q;
    base_d      = base_q;
    addr_d      = addr_q;
    newbase_d   = newbase_q;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    rf_addr_o   = '0;
    rf_we_o     = 1'b0;
    rf_wdata_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          p_d      = inst_i[24];
          u_d      = inst_i[23];
          w_d      = inst_i[21];
          l_d      = inst_i[20];
          rn_d     = inst_i[19:16];
          list_d   = inst_i[15:0];
          remain_d = inst_i[15:0];
          base_d   = rn_val_i;
          state_d  = CALC;
        end
      end
      CALC: begin
        busy_o    = 1'b1;
        addr_d    = {start_addr[ADDR_W-1:2], 2'b00};
        newbase_d = u_q ? base_q + span : base_q - span;
        state_d   = (list_q == '0) ? DONE : XFER;
      end
      XFER: begin
        busy_o     = 1'b1;
        mem_req_o  = 1'b1;
        mem_we_o   = ~l_q;
        mem_addr_o = addr_q;
        rf_addr_o  = cur_reg;
        if (!l_q) mem_wdata_o = rf_rdata_i;
        if (mem_ack_i) begin
          rf_we_o    = l_q;
          rf_wdata_o = l_q ? mem_rdata_i : 32'h0;
          addr_d     = addr_q + ADDR_W'(4);
          remain_d   = remain_next;
          if (remain_next == '0) state_d = w_q ? WB : DONE;
        end
      end
      WB: begin
        busy_o     = 1'b1;
        rf_addr_o  = rn_q;
        rf_wdata_o = 32'(newbase_q);
        // A base register that was also loaded keeps the loaded value.
        rf_we_o    = ~(l_q & list_q[rn_q]);
        state_d    = DONE;
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
